// File: rtl/led_share_arbiter_if.sv
// LED-bank sharing bus: requester side drives req/data, arbiter drives leds/grant/busy.
// Purely wiring; no latency and no backpressure.
interface led_share_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 5
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [WIDTH-1:0]      leds;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    modport master (output req, data, input leds, grant, busy);
    modport slave  (input req, data, output leds, grant, busy);
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin LED-bank arbiter with minimum dwell; all outputs registered, 1-cycle latency, no backpressure.
// Optional macro LED_ARB_PRIO_EN makes requester 0 a strict-priority preemptor.
module led_share_arbiter #(
    parameter int NREQ        = 3,
    parameter int WIDTH       = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    led_share_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_owner, w_owner_nxt;
    logic [IW-1:0]     r_last,  w_last_nxt;
    logic [DW-1:0]     r_dwell, w_dwell_nxt;
    logic [WIDTH-1:0]  r_leds,  w_leds_nxt;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic              r_busy,  w_busy_nxt;

    logic [IW-1:0]     w_pick;
    logic [IW-1:0]     w_new_idx;
    logic              w_grant_new;
    logic              w_others;

    // Search starts just after the last granted index, so the last owner is tried last.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_pick   = rr_pick(bus.req, r_last);
    assign w_others = |(bus.req & ~r_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_dwell_nxt = r_dwell;
        w_leds_nxt  = r_leds;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_grant_new = 1'b0;
`ifdef LED_ARB_PRIO_EN
        w_new_idx   = bus.req[0] ? '0 : w_pick;
`else
        w_new_idx   = w_pick;
`endif

        case (r_state)
            IDLE: begin
                w_leds_nxt  = '0;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_dwell_nxt = '0;
                if (|bus.req)
                    w_grant_new = 1'b1;
            end
            OWN: begin
                if (!bus.req[r_owner]) begin
                    if (|bus.req) begin
                        w_grant_new = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_leds_nxt  = '0;
                        w_grant_nxt = '0;
                        w_busy_nxt  = 1'b0;
                        w_dwell_nxt = '0;
                    end
                end
`ifdef LED_ARB_PRIO_EN
                else if (r_owner != '0 && bus.req[0])
                    w_grant_new = 1'b1;
                else if (r_owner != '0 && r_dwell == DWELL_MAX && w_others)
                    w_grant_new = 1'b1;
`else
                else if (r_dwell == DWELL_MAX && w_others)
                    w_grant_new = 1'b1;
`endif
                else begin
                    w_leds_nxt = bus.data[int'(r_owner)*WIDTH +: WIDTH];
                    if (r_dwell != DWELL_MAX)
                        w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_grant_new) begin
            w_state_nxt = OWN;
            w_owner_nxt = w_new_idx;
            w_last_nxt  = w_new_idx;
            w_dwell_nxt = '0;
            w_leds_nxt  = bus.data[int'(w_new_idx)*WIDTH +: WIDTH];
            w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_new_idx;
            w_busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IW'(NREQ - 1);
            r_dwell <= '0;
            r_leds  <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_dwell <= w_dwell_nxt;
            r_leds  <= w_leds_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bus.leds  = r_leds;
    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;
endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter at NREQ=3, WIDTH=5, HOLD_CYCLES=4.
module tb_led_share_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    led_share_arbiter_if #(.NREQ(3), .WIDTH(5)) ifc ();

    led_share_arbiter #(.NREQ(3), .WIDTH(5), .HOLD_CYCLES(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic [4:0] l, input logic b);
        chk({tag, ".grant"}, 32'(ifc.grant), 32'(g));
        chk({tag, ".leds"},  32'(ifc.leds),  32'(l));
        chk({tag, ".busy"},  32'(ifc.busy),  32'(b));
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    logic [2:0] exp_g;
    logic [4:0] exp_l;

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        ifc.req  = 3'b000;
        ifc.data = {5'h0C, 5'h0A, 5'h15};

        step();
        step();
        chk_out("reset", 3'b000, 5'h00, 1'b0);
        rst = 1'b0;

        // Sole requester 0 takes and holds the bank.
        ifc.req = 3'b001;
        step();
        chk_out("t1_grant", 3'b001, 5'h15, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t1_hold", 32'(ifc.grant), 32'h1);
        end
        ifc.data[4:0] = 5'h03;
        step();
        chk("t1_track", 32'(ifc.leds), 32'h03);

        // Asynchronous reset between edges, then restart from LAST=2.
        rst = 1'b1;
        #2;
        chk_out("t5_async", 3'b000, 5'h00, 1'b0);
        rst = 1'b0;
        ifc.data[4:0] = 5'h15;
        ifc.req = 3'b110;
        step();
        chk_out("t5_regrant", 3'b010, 5'h0A, 1'b1);

        // Owner 1 reaches dwell 1, then drops while 2 requests: direct hand-off.
        step();
        chk("t3_dwell1", 32'(ifc.grant), 32'h2);
        ifc.req = 3'b100;
        step();
        chk_out("t3_handoff", 3'b100, 5'h0C, 1'b1);

        // Release to idle, then wrap-around from LAST=1.
        ifc.req = 3'b000;
        step();
        chk_out("t4_idle", 3'b000, 5'h00, 1'b0);
        ifc.req = 3'b010;
        step();
        chk("t4_own1", 32'(ifc.grant), 32'h2);
        ifc.req = 3'b000;
        step();
        chk_out("t4_idle2", 3'b000, 5'h00, 1'b0);
        ifc.req = 3'b011;
        step();
        chk_out("t4_wrap", 3'b001, 5'h15, 1'b1);
        ifc.req = 3'b000;
        step();

        // Full contention: 4-cycle dwell per owner in order 0,1,2,0...
        rst_pulse();
        ifc.req = 3'b111;
        for (int i = 0; i < 14; i++) begin
            step();
            case ((i / 4) % 3)
                0:       begin exp_g = 3'b001; exp_l = 5'h15; end
                1:       begin exp_g = 3'b010; exp_l = 5'h0A; end
                default: begin exp_g = 3'b100; exp_l = 5'h0C; end
            endcase
            chk("t2_grant", 32'(ifc.grant), 32'(exp_g));
            chk("t2_leds",  32'(ifc.leds),  32'(exp_l));
        end

        // Owner 2 at dwell 0 when requester 0 rises.
        ifc.req = 3'b000;
        rst_pulse();
        ifc.req = 3'b100;
        step();
        chk("t6_own2", 32'(ifc.grant), 32'h4);
        ifc.req = 3'b101;
`ifdef LED_ARB_PRIO_EN
        step();
        chk("t6_preempt", 32'(ifc.grant), 32'h1);
`else
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_dwell", 32'(ifc.grant), 32'h4);
        end
        step();
        chk("t6_rotate", 32'(ifc.grant), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
